// File: rtl/grant_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | grant_decoder_pkg                                                    |
// | Shared state encoding and default widths for the grant decoder.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package grant_decoder_pkg;

   localparam int C_IDX_W = 3;
   localparam int C_N_OUT = 8;
   localparam int C_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/grant_decoder_onehot_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | onehot_dec                                                           |
// | Combinational IDX_W-to-N_OUT one-hot decoder with enable.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module onehot_dec
   import grant_decoder_pkg::*;
#(
   parameter int IDX_W = C_IDX_W,
   parameter int N_OUT = C_N_OUT
) (
   input  logic             en,
   input  logic [IDX_W-1:0] idx,
   output logic [N_OUT-1:0] y
);

   for (genvar i = 0; i < N_OUT; i++) begin : g_bit
      assign y[i] = en && (idx == IDX_W'(i));
   end

endmodule
`default_nettype wire

// File: rtl/grant_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | grant_decoder                                                        |
// | Turns an accepted encoded index into a registered one-hot grant held |
// | for max(hold_len,1) cycles. Define GRANT_DECODER_GAP_EN to insert a  |
// | one-cycle idle gap after every completed grant.                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module grant_decoder
   import grant_decoder_pkg::*;
#(
   parameter int N_OUT = C_N_OUT,
   parameter int IDX_W = C_IDX_W,
   parameter int CNT_W = C_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in,
   input  logic [CNT_W-1:0] hold_len,
   output logic [N_OUT-1:0] y,
   output logic             y_valid,
   output logic             done
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_len_m1;
   logic [N_OUT-1:0] r_y;
   logic [N_OUT-1:0] w_y_nxt;
   logic [N_OUT-1:0] w_dec;
   logic             r_y_valid;
   logic             w_y_valid_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             w_last;
   logic             w_last_ready;
   logic             w_accept;

   assign w_last = (r_state == GRANT) && (r_cnt == '0);

   // Without the gap, the final grant cycle may accept and chain the next grant.
`ifdef GRANT_DECODER_GAP_EN
   assign w_last_ready = 1'b0;
`else
   assign w_last_ready = w_last;
`endif

   assign in_ready = ena && !rst && ((r_state == IDLE) || w_last_ready);
   assign w_accept = in_valid && in_ready;
   assign w_len_m1 = (hold_len == '0) ? '0 : hold_len - CNT_W'(1);

   onehot_dec #(
      .IDX_W (IDX_W),
      .N_OUT (N_OUT)
   ) u_dec (
      .en  (w_accept),
      .idx (in),
      .y   (w_dec)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_y_nxt       = '0;
      w_y_valid_nxt = 1'b0;
      w_done_nxt    = 1'b0;
      if (!ena) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
      end else if (w_accept) begin
         w_state_nxt   = GRANT;
         w_cnt_nxt     = w_len_m1;
         w_y_nxt       = w_dec;
         w_y_valid_nxt = 1'b1;
         w_done_nxt    = (w_len_m1 == '0);
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = IDLE;
            end
            GRANT: begin
               if (r_cnt != '0) begin
                  w_cnt_nxt     = r_cnt - CNT_W'(1);
                  w_y_nxt       = r_y;
                  w_y_valid_nxt = 1'b1;
                  w_done_nxt    = (r_cnt == CNT_W'(1));
               end else begin
`ifdef GRANT_DECODER_GAP_EN
                  w_state_nxt = GAP;
`else
                  w_state_nxt = IDLE;
`endif
               end
            end
            GAP: begin
               w_state_nxt = IDLE;
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_y       <= '0;
         r_y_valid <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_y       <= w_y_nxt;
         r_y_valid <= w_y_valid_nxt;
         r_done    <= w_done_nxt;
      end
   end

   assign y       = r_y;
   assign y_valid = r_y_valid;
   assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_grant_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_grant_decoder                                                     |
// | Directed and randomized bench for grant_decoder with a cycle-time    |
// | reference model. Honours GRANT_DECODER_GAP_EN like the design.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_grant_decoder;

`ifdef GRANT_DECODER_GAP_EN
   localparam bit GAP_ON = 1'b1;
`else
   localparam bit GAP_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_idx = 3'd0;
   logic [3:0] hold_len = 4'd0;
   logic [7:0] y;
   logic       y_valid;
   logic       done;

   int checks   = 0;
   int failures = 0;

   grant_decoder dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in       (in_idx),
      .hold_len (hold_len),
      .y        (y),
      .y_valid  (y_valid),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive inputs for one cycle at the falling edge, then settle for sampling.
   task automatic step(input logic r, input logic e, input logic v, input int i, input int h);
      @(negedge clk);
      rst      = r;
      ena      = e;
      in_valid = v;
      in_idx   = i[2:0];
      hold_len = h[3:0];
      #2;
   endtask

   // Reference: a grant is a window [g_first, g_last] of cycle numbers.
   initial begin : p_model
      int         c     = 0;
      bit         gv    = 1'b0;
      int         gf    = 0;
      int         gl    = 0;
      int         gidx  = 0;
      int         len;
      logic [7:0] ey;
      logic       ed, er, bg, gapc, acc;
      @(posedge clk);
      forever begin
         @(negedge clk);
         #2;
         bg   = gv && (c >= gf) && (c <= gl);
         ed   = bg && (c == gl);
         gapc = GAP_ON && gv && (c == gl + 1);
         ey   = bg ? 8'(1 << gidx) : 8'h00;
         er   = ena && !rst && ((!bg && !gapc) || (ed && !GAP_ON));
         chk("model_y", y, ey);
         chk("model_y_valid", y_valid, ey != 8'h00);
         chk("model_done", done, ed);
         chk("model_in_ready", in_ready, er);
         acc = in_valid && er;
         if (rst || !ena) begin
            gv = 1'b0;
         end else if (acc) begin
            len  = (hold_len == 4'd0) ? 1 : int'(hold_len);
            gv   = 1'b1;
            gf   = c + 1;
            gl   = c + len;
            gidx = int'(in_idx);
         end
         c++;
      end
   end

   initial begin : p_stim
      logic [7:0] seq [6];
      int         n;

      repeat (3) step(1, 0, 0, 0, 0);
      chk("reset_y", y, 8'h00);
      chk("reset_y_valid", y_valid, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_in_ready", in_ready, 1'b0);
      step(0, 1, 0, 0, 0);
      chk("idle_in_ready", in_ready, 1'b1);

      // in=5, hold_len=3; in/hold_len wiggle during the grant
      step(0, 1, 1, 5, 3);
      chk("g5_pre_y", y, 8'h00);
      step(0, 1, 0, 2, 9);
      chk("g5_c1_y", y, 8'h20);
      chk("g5_c1_done", done, 1'b0);
      step(0, 1, 0, 6, 1);
      chk("g5_c2_y", y, 8'h20);
      step(0, 1, 0, 0, 0);
      chk("g5_c3_y", y, 8'h20);
      chk("g5_c3_done", done, 1'b1);
      step(0, 1, 0, 0, 0);
      chk("g5_after_y", y, 8'h00);
`ifdef GRANT_DECODER_GAP_EN
      chk("g5_gap_ready", in_ready, 1'b0);
`else
      chk("g5_idle_ready", in_ready, 1'b1);
`endif
      step(0, 1, 0, 0, 0);
      chk("g5_ready_back", in_ready, 1'b1);

      // hold_len=0 behaves as a single-cycle grant
      step(0, 1, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("g0_y", y, 8'h01);
      chk("g0_done", done, 1'b1);
      step(0, 1, 0, 0, 0);
      chk("g0_after_y", y, 8'h00);
      step(0, 1, 0, 0, 0);

      // ena dropped in the 2nd cycle of a 4-cycle grant
      step(0, 1, 1, 7, 4);
      step(0, 1, 0, 0, 0);
      chk("ab_c1_y", y, 8'h80);
      step(0, 0, 0, 0, 0);
      chk("ab_c2_y", y, 8'h80);
      step(0, 1, 0, 0, 0);
      chk("ab_after_y", y, 8'h00);
      repeat (4) begin
         step(0, 1, 0, 0, 0);
         chk("ab_no_done", done, 1'b0);
      end

      // back-to-back with in_valid held high
`ifdef GRANT_DECODER_GAP_EN
      seq[0] = 8'h80; seq[1] = 8'h80; seq[2] = 8'h00;
      seq[3] = 8'h00; seq[4] = 8'h01; seq[5] = 8'h01;
      n = 6;
`else
      seq[0] = 8'h80; seq[1] = 8'h80; seq[2] = 8'h01;
      seq[3] = 8'h01; seq[4] = 8'h00; seq[5] = 8'h00;
      n = 4;
`endif
      step(0, 1, 1, 7, 2);
      chk("b2b_pre_y", y, 8'h00);
      for (int k = 0; k < n; k++) begin
         step(0, 1, (k < n - 1), 0, 2);
         chk("b2b_y", y, seq[k]);
      end
      repeat (3) step(0, 1, 0, 0, 0);

      // reset held two cycles in the middle of a y=20 grant
      step(0, 1, 1, 5, 5);
      step(0, 1, 0, 0, 0);
      chk("rst_pre_y", y, 8'h20);
      step(1, 1, 0, 0, 0);
      chk("rst_c1_ready", in_ready, 1'b0);
      step(1, 1, 0, 0, 0);
      chk("rst_y", y, 8'h00);
      chk("rst_y_valid", y_valid, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ready", in_ready, 1'b0);
      step(0, 1, 0, 0, 0);
      chk("rst_idle_y", y, 8'h00);
      chk("rst_idle_ready", in_ready, 1'b1);

      repeat (3000) begin
         step(($urandom_range(0, 99) < 2),
              ($urandom_range(0, 99) >= 8),
              ($urandom_range(0, 99) < 60),
              int'($urandom_range(0, 7)),
              int'($urandom_range(0, 15)));
      end
      repeat (4) step(0, 1, 0, 0, 0);

      @(negedge clk);
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
